// File: rtl/vga_timing_pkg.sv
// Purpose: 640x480@60Hz timing constants and the colour type shared with the room map stages.
// Latency: none (declarations only).
// Backpressure: none; the scan is free-running.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;   // 800
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;   // 525
    localparam int HS_START = H_VISIBLE + H_FRONT;                     // 656
    localparam int HS_END   = HS_START + H_SYNC - 1;                   // 751
    localparam int VS_START = V_VISIBLE + V_FRONT;                     // 490
    localparam int VS_END   = VS_START + V_SYNC - 1;                   // 491

    // 8-bit RRRGGGBB pixel as produced by the room map stages
    typedef logic [7:0] color_t;

endpackage

// File: rtl/sig_delay.sv
// Purpose: fixed-depth shift register with asynchronous reset to a programmable value.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; shifts every cycle.
module sig_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// Purpose: VGA raster scan; presents CurrentX/Y to the map stages, returns sync plus blanked colour.
// Latency: MAP_LAT+1 cycles from counter state to hsync/vsync/videoOn/frameStart/vgaColor.
// Backpressure: none; free-running at the pixel clock, mapData is sampled every cycle.
// Ports: clk_vga/rst_n clock and async reset; mapData colour in; CurrentX/CurrentY scan coordinate
//        out (0 in blanking); hsync/vsync/videoOn/vgaColor/frameStart registered, mutually aligned.
module vga_scan_gen #(
    parameter int   H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int   H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK    = vga_timing_pkg::H_BACK,
    parameter int   V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int   V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK    = vga_timing_pkg::V_BACK,
    parameter int   MAP_LAT   = 1,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic                  clk_vga,
    input  logic                  rst_n,
    input  vga_timing_pkg::color_t mapData,
    output logic [9:0]            CurrentX,
    output logic [8:0]            CurrentY,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  videoOn,
    output vga_timing_pkg::color_t vgaColor,
    output logic                  frameStart
);

    import vga_timing_pkg::*;

    localparam int H_TOT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEG = H_VISIBLE + H_FRONT;
    localparam int HS_LST = HS_BEG + H_SYNC - 1;
    localparam int VS_BEG = V_VISIBLE + V_FRONT;
    localparam int VS_LST = VS_BEG + V_SYNC - 1;

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       h_last;
    logic       v_last;

    assign h_last = (hcnt == 10'(H_TOT - 1));
    assign v_last = (vcnt == 10'(V_TOT - 1));

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? 10'd0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    // Coordinates go straight to the map stages; they are the only unregistered outputs.
    always_comb begin
        CurrentX = (hcnt < 10'(H_VISIBLE)) ? hcnt : 10'd0;
        CurrentY = (vcnt < 10'(V_VISIBLE)) ? vcnt[8:0] : 9'd0;
    end

    logic vis_raw, hs_raw, vs_raw, fs_raw;

    always_comb begin
        vis_raw = (hcnt < 10'(H_VISIBLE)) && (vcnt < 10'(V_VISIBLE));
        hs_raw  = ((hcnt >= 10'(HS_BEG)) && (hcnt <= 10'(HS_LST))) ? SYNC_POL : ~SYNC_POL;
        vs_raw  = ((vcnt >= 10'(VS_BEG)) && (vcnt <= 10'(VS_LST))) ? SYNC_POL : ~SYNC_POL;
        fs_raw  = (hcnt == 10'd0) && (vcnt == 10'd0);
    end

    // Timing bits wait out the map-stage latency so they meet mapData in the output register.
    logic vis_d, hs_d, vs_d, fs_d;

    sig_delay #(
        .WIDTH     (4),
        .DEPTH     (MAP_LAT),
        .RESET_VAL ({1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_timing_dly (
        .clk   (clk_vga),
        .rst_n (rst_n),
        .din   ({fs_raw, vs_raw, hs_raw, vis_raw}),
        .dout  ({fs_d, vs_d, hs_d, vis_d})
    );

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            vgaColor   <= '0;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            videoOn    <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            vgaColor   <= vis_d ? mapData : 8'h00;
            hsync      <= hs_d;
            vsync      <= vs_d;
            videoOn    <= vis_d;
            frameStart <= fs_d;
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
module tb_vga_scan_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
        logic [7:0] col;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_done = 0;

    // Instance 0: full 640x480 timing, MAP_LAT=1, active-low sync.
    // Instance 1: shrunken raster so whole frames fit, MAP_LAT=3, active-high sync.
    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int HV  = (g == 0) ? 640 : 20;
        localparam int HF  = (g == 0) ? 16  : 3;
        localparam int HS  = (g == 0) ? 96  : 5;
        localparam int HB  = (g == 0) ? 48  : 4;
        localparam int VV  = (g == 0) ? 480 : 12;
        localparam int VF  = (g == 0) ? 10  : 2;
        localparam int VS  = (g == 0) ? 2   : 2;
        localparam int VB  = (g == 0) ? 33  : 3;
        localparam int LAT = (g == 0) ? 1   : 3;
        localparam logic POL = (g == 0) ? 1'b0 : 1'b1;
        localparam int HT  = HV + HF + HS + HB;
        localparam int VT  = VV + VF + VS + VB;
        localparam int FRAME = HT * VT;

        logic       rst_n;
        logic [7:0] map_data;
        logic [9:0] cur_x;
        logic [8:0] cur_y;
        logic       hsync, vsync, video_on, frame_start;
        logic [7:0] vga_color;

        logic [7:0] lut [256];
        logic       ff_mode;
        logic [7:0] map_pipe [LAT];
        exp_t       q [$];

        vga_scan_gen #(
            .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
            .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
            .MAP_LAT(LAT), .SYNC_POL(POL)
        ) dut (
            .clk_vga    (clk),
            .rst_n      (rst_n),
            .mapData    (map_data),
            .CurrentX   (cur_x),
            .CurrentY   (cur_y),
            .hsync      (hsync),
            .vsync      (vsync),
            .videoOn    (video_on),
            .vgaColor   (vga_color),
            .frameStart (frame_start)
        );

        // Pixel content of the imaginary room: random table keyed by position, or solid 0xFF.
        function automatic logic [7:0] map_fn(input int x, input int y);
            if (ff_mode) return 8'hFF;
            return lut[(x + 37 * y) & 255];
        endfunction

        // Map stage stand-in: LAT registers from the coordinate the DUT presents.
        always @(posedge clk) begin
            map_pipe[0] <= map_fn(int'(cur_x), int'(cur_y));
            for (int i = 1; i < LAT; i++) map_pipe[i] <= map_pipe[i-1];
        end
        assign map_data = map_pipe[LAT-1];

        // Expected pins after k clock edges since reset release (k=0: in reset / just released).
        function automatic exp_t model(input int k);
            exp_t e;
            int   p, ox, oy, cx, cy;
            p  = k % FRAME;
            cx = p % HT;
            cy = p / HT;
            e.x = (cx < HV) ? 10'(cx) : 10'd0;
            e.y = (cy < VV) ? 9'(cy) : 9'd0;
            if (k < LAT + 1) begin
                e.hs = ~POL; e.vs = ~POL; e.von = 1'b0; e.fs = 1'b0; e.col = 8'h00;
            end else begin
                p  = (k - LAT - 1) % FRAME;
                ox = p % HT;
                oy = p / HT;
                e.von = (ox < HV) && (oy < VV);
                e.hs  = (ox >= HV + HF && ox < HV + HF + HS) ? POL : ~POL;
                e.vs  = (oy >= VV + VF && oy < VV + VF + VS) ? POL : ~POL;
                e.fs  = (ox == 0) && (oy == 0);
                e.col = e.von ? map_fn(ox, oy) : 8'h00;
            end
            return e;
        endfunction

        // Stimulus: reset, free run, asynchronous mid-frame reset, free run again.
        initial begin
            int k;
            int hold;
            int stop_at;
            int run2;
            rst_n   = 1'b0;
            ff_mode = 1'b0;
            for (int i = 0; i < LAT; i++) map_pipe[i] = 8'h00;
            for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
            lut[5] = 8'hFE;

            hold = int'($urandom_range(14, 10));
            repeat (hold) begin
                @(posedge clk); #1;
                q.push_back(model(0));
            end
            @(posedge clk); #1;
            rst_n = 1'b1;
            q.push_back(model(0));
            k = 0;

            stop_at = (g == 0) ? (2 * HT + 300) : (3 * FRAME + 7 * HT + int'($urandom_range(HT - 1, 0)));
            while (k < stop_at) begin
                @(posedge clk); #1;
                k++;
                q.push_back(model(k));
            end

            // Asynchronous assertion between edges; pins must clear before the next edge.
            @(posedge clk); #2;
            rst_n = 1'b0;
            q.push_back(model(0));
            ff_mode = 1'b1;
            hold = int'($urandom_range(8, 5));
            repeat (hold) begin
                @(posedge clk); #1;
                q.push_back(model(0));
            end
            @(posedge clk); #1;
            rst_n = 1'b1;
            q.push_back(model(0));
            k = 0;
            run2 = (g == 0) ? (HT + 100) : (2 * FRAME + 50);
            while (k < run2) begin
                @(posedge clk); #1;
                k++;
                q.push_back(model(k));
            end
            @(negedge clk); #1;
            n_done++;
        end

        // Monitor: pop one expectation per cycle, plus frame-level spacing/visible-count checks.
        int cyc     = 0;
        int last_fs = -1;
        int von_cnt = 0;

        always @(negedge clk) begin
            exp_t e, a;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{x: cur_x, y: cur_y, hs: hsync, vs: vsync, von: video_on,
                      fs: frame_start, col: vga_color};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL inst%0d pins cyc=%0d got x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b col=%02h want x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b col=%02h",
                             g, cyc, a.x, a.y, a.hs, a.vs, a.von, a.fs, a.col,
                             e.x, e.y, e.hs, e.vs, e.von, e.fs, e.col);
                end
            end
            if (!rst_n) begin
                last_fs = -1;
                von_cnt = 0;
            end else if (frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != FRAME) begin
                        errors++;
                        $display("FAIL inst%0d frame_spacing got %0d want %0d", g, cyc - last_fs, FRAME);
                    end
                    checks++;
                    if (von_cnt != HV * VV) begin
                        errors++;
                        $display("FAIL inst%0d visible_per_frame got %0d want %0d", g, von_cnt, HV * VV);
                    end
                end
                last_fs = cyc;
                von_cnt = video_on ? 1 : 0;
            end else if (video_on) begin
                von_cnt++;
            end
        end
    end

    initial begin
        wait (n_done == 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
